// File: rtl/acc_pkg.sv
// acc_pkg: shared widths and serializer state encoding for the
// accumulator output port.
package acc_pkg;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } state_t;

endpackage

// File: rtl/acc_word_fifo.sv
// acc_word_fifo: synchronous word FIFO, async active-low reset.
// Ports: push/push_data in, pop in, head/full/count out.
module acc_word_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_en;
  logic          rd_en;

  // Full comes from the pre-edge count, so a same-edge pop
  // never makes room for a push.
  assign full  = (count == CW'(DEPTH));
  assign wr_en = push && !full;
  assign rd_en = pop && (count != '0);
  assign head  = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/acc_out_port.sv
// acc_out_port: captures accumulator words on OUT and sends each
// as two byte beats (high first) on a valid/ready channel.
module acc_out_port #(
  parameter int DATA_W = acc_pkg::DATA_W,
  parameter int BYTE_W = acc_pkg::BYTE_W,
  parameter int DEPTH  = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] acc_in,
  input  logic              out_req,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              drained,
  output logic              overflow
);

  import acc_pkg::*;

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] head;
  logic              hs;
  logic              pop;
  logic              have;

  acc_word_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (out_req),
    .push_data (acc_in),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .count     (count)
  );

  assign hs   = tx_valid && tx_ready;
  assign have = (count != '0);

  // Refill from IDLE, or straight after the low beat so
  // consecutive words leave without a bubble.
  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE:    pop = have;
      SEND_LO: pop = hs && have;
      default: pop = 1'b0;
    endcase
  end

  assign drained = (state == IDLE) && !have && !out_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sreg     <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (out_req && full) overflow <= 1'b1;
      if (pop) begin
        state    <= SEND_HI;
        sreg     <= head;
        tx_data  <= head[DATA_W-1 -: BYTE_W];
        tx_valid <= 1'b1;
        tx_last  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          SEND_HI: begin
            if (hs) begin
              state   <= SEND_LO;
              tx_data <= sreg[BYTE_W-1:0];
              tx_last <= 1'b1;
            end
          end
          SEND_LO: begin
            if (hs) begin
              state    <= IDLE;
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/acc_out_port.md
Name: acc_out_port

Overview:
- Output-side consumer of the accumulator. An OUT instruction strobe captures the 16-bit accumulator value into a small word FIFO.
- The block then serializes each word as two 8-bit beats, high byte first, on a valid/ready byte channel toward the board I/O.
- It raises `full` so the control unit can stall OUT instructions, and `drained` so HALT can wait for all output to finish.

Parameters:
- DATA_W, 16, accumulator word width; must be 2*BYTE_W.
- BYTE_W, 8, width of one transmitted beat.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- acc_in  input  DATA_W  accumulator value, sampled only when out_req=1.
- out_req  input  1  one-cycle push strobe from control (OUT instruction).
- full  output  1  FIFO holds DEPTH words; a push this cycle is ignored.
- count  output  $clog2(DEPTH)+1  words stored in the FIFO, excluding the word currently being sent.
- tx_data  output  BYTE_W  current beat.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the beat.
- tx_last  output  1  high during the low-byte beat of a word.
- drained  output  1  FIFO empty, state IDLE and no push pending this cycle.
- overflow  output  1  sticky; set when out_req arrives while full; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous) forces the following, and any in-flight word is discarded:
  - state IDLE
  - FIFO pointers and count 0
  - tx_valid 0, tx_last 0, tx_data 0
  - full 0, overflow 0, drained 1
- Push rules:
  - At a rising edge with out_req=1 and full=0, acc_in is written at the write pointer; the pointer increments modulo DEPTH.
  - At a rising edge with out_req=1 and full=1, nothing is written and overflow is set.
  - A pop in the same cycle does not make room for that push; the decision uses the pre-edge `full`.
- Beat handshake: a beat transfers at a rising edge where tx_valid=1 and tx_ready=1.
- Output stability: while tx_valid=1 and tx_ready=0, tx_data and tx_last hold steady. tx_valid never drops without a transfer, except on reset.
- State machine: three states, IDLE, SEND_HI and SEND_LO. The 16-bit shift register holds the word being sent.
  - IDLE: if count>0, pop the FIFO head into the shift register and go to SEND_HI. Otherwise stay in IDLE.
  - SEND_HI: tx_valid=1, tx_data = word[15:8], tx_last=0. On handshake, go to SEND_LO.
  - SEND_LO: tx_valid=1, tx_data = word[7:0], tx_last=1. On handshake:
    - if count>0 (pre-edge), pop the next word into the shift register and go to SEND_HI, with no bubble;
    - otherwise go to IDLE.
- Latency: with the FIFO empty and state IDLE, a push at edge E0 puts the high byte valid after edge E1. The minimum word period is 2 cycles when tx_ready is held at 1.
- Simultaneous push and pop: both happen and count is unchanged. With DEPTH=4 and count=4, a push is still rejected even if a pop occurs at the same edge.
- Pointer wrap: pointers wrap modulo DEPTH. `full` is derived from count, so there is no full/empty aliasing.
- All outputs are registered, except `drained`, which is the combinational AND of: state==IDLE, count==0, and out_req==0.

Decomposition:
- Shared package (acc_pkg): DATA_W and BYTE_W constants, and the state enum {IDLE, SEND_HI, SEND_LO}.
- One sub-module, acc_word_fifo:
  - parameterized synchronous FIFO with push/pop/full/count;
  - async active-low reset.
- acc_out_port instantiates acc_word_fifo and contains the serializer FSM and the shift register.

Test Plan:
1. Reset mid-transfer: push 0xBEEF, assert reset=0 while in SEND_LO -> tx_valid=0 immediately, count=0, drained=1, no further beats after release.
2. Single word, tx_ready=1: push 0x1234 at E0 -> beats 0x12 (tx_last=0) after E1, then 0x34 (tx_last=1) after E2; IDLE and drained=1 after E3.
3. Back-pressure: push 0xA55A, hold tx_ready=0 for 5 cycles -> tx_data stays 0xA5 with tx_valid=1; release -> 0xA5 then 0x5A, no duplicates.
4. Back-to-back: push 0x0102, 0x0304, 0x0506 on consecutive cycles, tx_ready=1 -> byte stream 01 02 03 04 05 06 with no idle cycle between words; count peaks at 2.
5. Full/overflow with DEPTH=4 and tx_ready=0:
   - push 5 words -> full=1 after 4 in FIFO plus 1 in flight, 6th push rejected, overflow=1;
   - release tx_ready -> exactly the first 5 words emerge, in order.
6. Wrap-around: push and drain 10 words with random tx_ready -> all 20 bytes in order; pointers wrap without loss; overflow stays 0.
